// File: rtl/fsm_stream_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : fsm_stream_arbiter_if
//  Description : Bundle of request/frame/grant/result signals plus the link
//                to the shared serial Mealy detector.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fsm_stream_arbiter_if #(
   parameter int NREQ = 4
);
   logic [NREQ-1:0]         req;
   logic [8*NREQ-1:0]       data;
   logic [NREQ-1:0]         gnt;
   logic                    busy;
   logic                    done;
   logic [$clog2(NREQ)-1:0] done_id;
   logic [3:0]              result_cnt;
   logic                    det_rst;
   logic                    det_din;
   logic                    det_dout;

   // Environment side: requesters and the detector
   modport master (
      output req, data, det_dout,
      input  gnt, busy, done, done_id, result_cnt, det_rst, det_din
   );

   // Arbiter side
   modport slave (
      input  req, data, det_dout,
      output gnt, busy, done, done_id, result_cnt, det_rst, det_din
   );
endinterface
`default_nettype wire

// File: rtl/fsm_stream_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fsm_stream_arbiter
//  Description : Round-robin arbiter that latches the winner's frame byte and
//                streams it MSB-first through a shared Mealy detector,
//                counting detector hits and reporting them per frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module fsm_stream_arbiter #(
   parameter int NREQ      = 4,
   parameter int FRAME_LEN = 8
) (
   input  wire logic             clk,
   input  wire logic             rst_n,
   fsm_stream_arbiter_if.slave   bus
);
   localparam int IDW  = $clog2(NREQ);
   localparam int BCW  = $clog2(FRAME_LEN);
   localparam int CNTW = 4;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_GRANT = 3'd1;
   localparam logic [2:0] S_PRIME = 3'd2;
   localparam logic [2:0] S_SHIFT = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]           state_q, state_d;
   logic [IDW-1:0]       ptr_q, ptr_d;
   logic [IDW-1:0]       cur_id_q, cur_id_d;
   logic [FRAME_LEN-1:0] shreg_q, shreg_d;
   logic [BCW-1:0]       bitcnt_q, bitcnt_d;
   logic [CNTW-1:0]      count_q, count_d;
   logic [NREQ-1:0]      gnt_q, gnt_d;
   logic                 done_q, done_d;
   logic [IDW-1:0]       done_id_q, done_id_d;
   logic [CNTW-1:0]      result_cnt_q, result_cnt_d;
   logic                 det_rst_q, det_rst_d;
   logic                 det_din_q, det_din_d;

   logic                 win_vld_w;
   logic [IDW-1:0]       win_id_w;

   // Round-robin pick: first requester at or after ptr (descending scan so
   // the smallest offset from ptr is the last assignment to stick)
   always_comb begin
      win_vld_w = |bus.req;
      win_id_w  = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (bus.req[ptr_q + IDW'(k)]) begin
            win_id_w = ptr_q + IDW'(k);
         end
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; IDLE always lasts at least one cycle after DONE
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (win_vld_w) state_d = S_GRANT;
         S_GRANT: state_d = S_PRIME;
         S_PRIME: state_d = S_SHIFT;
         S_SHIFT: if (bitcnt_q == BCW'(FRAME_LEN - 1)) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Next values of datapath and registered outputs, keyed on the transition
   always_comb begin
      ptr_d        = ptr_q;
      cur_id_d     = cur_id_q;
      shreg_d      = shreg_q;
      bitcnt_d     = bitcnt_q;
      count_d      = count_q;
      gnt_d        = gnt_q;
      done_d       = 1'b0;
      done_id_d    = done_id_q;
      result_cnt_d = result_cnt_q;
      det_rst_d    = 1'b1;
      det_din_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            gnt_d = '0;
            if (state_d == S_GRANT) begin
               cur_id_d  = win_id_w;
               shreg_d   = bus.data[int'(win_id_w) * FRAME_LEN +: FRAME_LEN];
               gnt_d     = NREQ'(1) << win_id_w;
               det_rst_d = 1'b0;   // detector back to idle during GRANT
            end
         end
         S_GRANT: begin
            count_d = '0;
         end
         S_PRIME: begin
            // First frame bit must already be on det_din in SHIFT cycle 0
            det_din_d = shreg_q[FRAME_LEN-1];
            shreg_d   = shreg_q << 1;
            bitcnt_d  = '0;
         end
         S_SHIFT: begin
            count_d  = count_q + CNTW'(bus.det_dout);
            bitcnt_d = bitcnt_q + BCW'(1);
            if (state_d == S_SHIFT) begin
               det_din_d = shreg_q[FRAME_LEN-1];
               shreg_d   = shreg_q << 1;
            end else begin
               done_d       = 1'b1;
               done_id_d    = cur_id_q;
               result_cnt_d = count_q + CNTW'(bus.det_dout);
            end
         end
         S_DONE: begin
            gnt_d = '0;
            ptr_d = cur_id_q + IDW'(1);
         end
         default: begin
            gnt_d = '0;
         end
      endcase
   end

   // Datapath and output registers; reset aborts any frame in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q        <= '0;
         cur_id_q     <= '0;
         shreg_q      <= '0;
         bitcnt_q     <= '0;
         count_q      <= '0;
         gnt_q        <= '0;
         done_q       <= 1'b0;
         done_id_q    <= '0;
         result_cnt_q <= '0;
         det_rst_q    <= 1'b0;
         det_din_q    <= 1'b0;
      end else begin
         ptr_q        <= ptr_d;
         cur_id_q     <= cur_id_d;
         shreg_q      <= shreg_d;
         bitcnt_q     <= bitcnt_d;
         count_q      <= count_d;
         gnt_q        <= gnt_d;
         done_q       <= done_d;
         done_id_q    <= done_id_d;
         result_cnt_q <= result_cnt_d;
         det_rst_q    <= det_rst_d;
         det_din_q    <= det_din_d;
      end
   end

   assign bus.gnt        = gnt_q;
   assign bus.busy       = (state_q != S_IDLE);
   assign bus.done       = done_q;
   assign bus.done_id    = done_id_q;
   assign bus.result_cnt = result_cnt_q;
   assign bus.det_rst    = det_rst_q;
   assign bus.det_din    = det_din_q;

endmodule
`default_nettype wire
